// File: rtl/clk_rst_seq_if.sv
// Signal bundle between the clock/reset sequencer and the MMCM plus push-button side.
// The master modport is the sequencer itself; the slave modport is the environment it controls.
interface clk_rst_seq_if;
  logic       mmcm_locked;
  logic       ext_rst_req;
  logic       mmcm_rst;
  logic       sys_rst;
  logic       lock_lost;
  logic [3:0] fail_cnt;
  logic [1:0] state;

  modport master (
    input  mmcm_locked,
    input  ext_rst_req,
    output mmcm_rst,
    output sys_rst,
    output lock_lost,
    output fail_cnt,
    output state
  );

  modport slave (
    output mmcm_locked,
    output ext_rst_req,
    input  mmcm_rst,
    input  sys_rst,
    input  lock_lost,
    input  fail_cnt,
    input  state
  );
endinterface

// File: rtl/clk_rst_seq.sv
// MMCM reset / lock supervisor: pulses the MMCM reset, waits for lock, lets it settle,
// then releases the system reset; restarts on lock loss, timeout or a debounced button.
module clk_rst_seq #(
  parameter int unsigned MMCM_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT    = 1048576,
  parameter int unsigned SETTLE_CYCLES   = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 256
) (
  input  logic          clk_in1,
  input  logic          reset,
  clk_rst_seq_if.master bus
);

  typedef enum logic [1:0] {
    ST_MMCM_RST  = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // The shared counter only ever has to reach (limit - 1) of the largest per-state limit.
  localparam int unsigned CNT_MAX_A = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DEB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE      = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             locked_meta_r;
  logic             locked_s;
  logic             ext_meta_r;
  logic             ext_s;
  logic [DEB_W-1:0] deb_cnt_r;
  logic             deb_done_r;
  logic             req_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             mmcm_rst_r;
  logic             sys_rst_r;
  logic             lock_lost_r;
  logic [3:0]       fail_cnt_r;

  // Two-flop synchronizers for the asynchronous lock and button inputs.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      locked_meta_r <= 1'b0;
      locked_s      <= 1'b0;
      ext_meta_r    <= 1'b0;
      ext_s         <= 1'b0;
    end else begin
      locked_meta_r <= bus.mmcm_locked;
      locked_s      <= locked_meta_r;
      ext_meta_r    <= bus.ext_rst_req;
      ext_s         <= ext_meta_r;
    end
  end

  // Button debounce: one req pulse per continuous high run of DEBOUNCE_CYCLES or longer.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      deb_cnt_r  <= '0;
      deb_done_r <= 1'b0;
      req_r      <= 1'b0;
    end else if (!ext_s) begin
      deb_cnt_r  <= '0;
      deb_done_r <= 1'b0;
      req_r      <= 1'b0;
    end else if (deb_done_r) begin
      req_r      <= 1'b0;
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_done_r <= 1'b1;
      req_r      <= 1'b1;
    end else begin
      deb_cnt_r  <= deb_cnt_r + DEB_ONE;
      req_r      <= 1'b0;
    end
  end

  // Sequencer FSM; outputs are updated on the same edge as the state they belong to.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_r     <= ST_MMCM_RST;
      cnt_r       <= '0;
      mmcm_rst_r  <= 1'b1;
      sys_rst_r   <= 1'b1;
      lock_lost_r <= 1'b0;
      fail_cnt_r  <= 4'd0;
    end else begin
      lock_lost_r <= 1'b0;
      case (state_r)
        ST_MMCM_RST: begin
          if (cnt_r == MMCM_LAST) begin
            state_r    <= ST_WAIT_LOCK;
            cnt_r      <= '0;
            mmcm_rst_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (req_r) begin
            state_r    <= ST_MMCM_RST;
            cnt_r      <= '0;
            mmcm_rst_r <= 1'b1;
          end else if (locked_s) begin
            state_r <= ST_SETTLE;
            cnt_r   <= '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r    <= ST_MMCM_RST;
            cnt_r      <= '0;
            mmcm_rst_r <= 1'b1;
            if (fail_cnt_r != 4'd15) begin
              fail_cnt_r <= fail_cnt_r + 4'd1;
            end else begin
              fail_cnt_r <= fail_cnt_r;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SETTLE: begin
          // A lock drop here is treated as a still-settling MMCM, so no MMCM reset.
          if (!locked_s) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (req_r) begin
            state_r    <= ST_MMCM_RST;
            cnt_r      <= '0;
            mmcm_rst_r <= 1'b1;
          end else if (cnt_r == SETTLE_LAST) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            sys_rst_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_r     <= ST_MMCM_RST;
            cnt_r       <= '0;
            mmcm_rst_r  <= 1'b1;
            sys_rst_r   <= 1'b1;
            lock_lost_r <= 1'b1;
          end else if (req_r) begin
            state_r    <= ST_MMCM_RST;
            cnt_r      <= '0;
            mmcm_rst_r <= 1'b1;
            sys_rst_r  <= 1'b1;
          end else begin
            cnt_r <= '0;
          end
        end
        default: begin
          state_r    <= ST_MMCM_RST;
          cnt_r      <= '0;
          mmcm_rst_r <= 1'b1;
          sys_rst_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mmcm_rst  = mmcm_rst_r;
  assign bus.sys_rst   = sys_rst_r;
  assign bus.lock_lost = lock_lost_r;
  assign bus.fail_cnt  = fail_cnt_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: a cycle-level reference model predicts every output change,
// a separate monitor compares each observed output change against the predicted queue.
module tb_clk_rst_seq;
  localparam int P_MR = 4;
  localparam int P_LT = 32;
  localparam int P_SC = 8;
  localparam int P_DB = 4;

  localparam int S_MR  = 0;
  localparam int S_WL  = 1;
  localparam int S_SET = 2;
  localparam int S_RUN = 3;

  typedef struct packed {
    logic [1:0] st;
    logic       mr;
    logic       sr;
    logic       ll;
    logic [3:0] fc;
  } out_t;

  localparam out_t RST_OUT = '{st: 2'd0, mr: 1'b1, sr: 1'b1, ll: 1'b0, fc: 4'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  clk_rst_seq_if bus ();

  clk_rst_seq #(
    .MMCM_RST_CYCLES (P_MR),
    .LOCK_TIMEOUT    (P_LT),
    .SETTLE_CYCLES   (P_SC),
    .DEBOUNCE_CYCLES (P_DB)
  ) dut (
    .clk_in1 (clk),
    .reset   (reset),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  out_t exp_q[$];
  int   exp_cyc_q[$];

  // Reference model: raw input history plus state / time-in-state bookkeeping.
  bit   lk_raw[$];
  int   ex_run[$];
  int   m_st, m_t, m_fc;
  bit   m_ll;
  out_t m_prev;

  function automatic bit lk_at(int i);
    return (i < 1) ? 1'b0 : lk_raw[i];
  endfunction

  function automatic int run_at(int i);
    return (i < 1) ? 0 : ex_run[i];
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.st = 2'(m_st);
    o.mr = (m_st == S_MR);
    o.sr = (m_st != S_RUN);
    o.ll = m_ll;
    o.fc = 4'(m_fc);
    return o;
  endfunction

  function automatic void enter(int s);
    m_st = s;
    m_t  = 0;
  endfunction

  function automatic void model_reset();
    cyc = 0;
    lk_raw.delete(); lk_raw.push_back(1'b0);
    ex_run.delete(); ex_run.push_back(0);
    m_st = S_MR; m_t = 0; m_fc = 0; m_ll = 1'b0;
    m_prev = model_out();
    exp_q.delete(); exp_cyc_q.delete();
  endfunction

  // One clock edge: the synchronized lock is the raw input two edges back, and a
  // button request reaches the sequencer one edge after a high run first hits P_DB.
  function automatic void model_edge(bit l, bit e);
    bit lk, rq;
    out_t o;
    cyc++;
    lk_raw.push_back(l);
    ex_run.push_back(e ? run_at(cyc - 1) + 1 : 0);
    lk = lk_at(cyc - 2);
    rq = (run_at(cyc - 3) == P_DB);
    m_ll = 1'b0;
    case (m_st)
      S_MR: begin
        m_t++;
        if (m_t == P_MR) enter(S_WL);
      end
      S_WL: begin
        if (rq) enter(S_MR);
        else if (lk) enter(S_SET);
        else if (m_t + 1 == P_LT) begin enter(S_MR); if (m_fc < 15) m_fc++; end
        else m_t++;
      end
      S_SET: begin
        if (!lk) enter(S_WL);
        else if (rq) enter(S_MR);
        else if (m_t + 1 == P_SC) enter(S_RUN);
        else m_t++;
      end
      default: begin
        if (!lk) begin enter(S_MR); m_ll = 1'b1; end
        else if (rq) enter(S_MR);
      end
    endcase
    o = model_out();
    if (o != m_prev) begin
      exp_q.push_back(o);
      exp_cyc_q.push_back(cyc);
    end
    m_prev = o;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic step(input bit l, input bit e);
    bus.mmcm_locked = l;
    bus.ext_rst_req = e;
    @(posedge clk);
    model_edge(l, e);
    @(negedge clk);
  endtask

  task automatic run_until(input int target, input bit l, input int limit, input string nm);
    int n = 0;
    while (m_st != target && n < limit) begin
      step(l, 1'b0);
      n++;
    end
    if (m_st != target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: model state %0d after %0d cycles, expected %0d", nm, m_st, n, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},     int'(bus.state),     0);
    chk({tag, "_mmcm_rst"},  int'(bus.mmcm_rst),  1);
    chk({tag, "_sys_rst"},   int'(bus.sys_rst),   1);
    chk({tag, "_lock_lost"}, int'(bus.lock_lost), 0);
    chk({tag, "_fail_cnt"},  int'(bus.fail_cnt),  0);
  endtask

  // Monitor: every change of the DUT outputs must match the next predicted change.
  initial begin
    out_t prev, cur, want;
    int   wcyc;
    prev = RST_OUT;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = RST_OUT;
      end else begin
        cur = '{st: bus.state, mr: bus.mmcm_rst, sr: bus.sys_rst, ll: bus.lock_lost, fc: bus.fail_cnt};
        if (cur != prev) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL seq_unexpected: cyc %0d got st=%0d mr=%0b sr=%0b ll=%0b fc=%0d, expected no change",
                     cyc, cur.st, cur.mr, cur.sr, cur.ll, cur.fc);
          end else begin
            want = exp_q.pop_front();
            wcyc = exp_cyc_q.pop_front();
            if (want != cur || wcyc != cyc) begin
              n_bad++;
              $display("FAIL seq_change: got cyc %0d st=%0d mr=%0b sr=%0b ll=%0b fc=%0d, expected cyc %0d st=%0d mr=%0b sr=%0b ll=%0b fc=%0d",
                       cyc, cur.st, cur.mr, cur.sr, cur.ll, cur.fc,
                       wcyc, want.st, want.mr, want.sr, want.ll, want.fc);
            end
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    bus.mmcm_locked = 1'b0;
    bus.ext_rst_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // Power-up with lock already present.
    reset = 1'b0;
    model_reset();
    run_until(S_RUN, 1'b1, 50, "powerup");
    repeat (5) step(1'b1, 1'b0);

    // Lock loss in RUN, then full sequence again.
    step(1'b0, 1'b0);
    run_until(S_RUN, 1'b1, 60, "relock");

    // No lock for long enough to saturate fail_cnt.
    repeat (600) step(1'b0, 1'b0);
    run_until(S_RUN, 1'b1, 80, "lock_after_timeouts");

    // Short button bursts are ignored, a long hold restarts exactly once.
    for (int b = 0; b < 3; b++) begin
      repeat (3) step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
    end
    repeat (50) step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    run_until(S_RUN, 1'b1, 60, "after_button");
    repeat (3) step(1'b1, 1'b0);

    // Lock loss and debounced request landing on the same edge in RUN.
    for (int i = 0; i < P_DB + 10; i++) step((i == P_DB) ? 1'b0 : 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    run_until(S_RUN, 1'b1, 60, "after_coincide");

    // Single-cycle lock glitch part way through SETTLE.
    step(1'b0, 1'b0);
    run_until(S_SET, 1'b1, 60, "to_settle");
    while (m_st == S_SET && m_t < 5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    run_until(S_RUN, 1'b1, 60, "after_glitch");

    // Asynchronous reset in the middle of SETTLE.
    step(1'b0, 1'b0);
    run_until(S_SET, 1'b1, 60, "to_settle2");
    while (m_st == S_SET && m_t < 3) step(1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    chk("pending_before_reset", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Randomized segments of lock/button activity.
    for (int s = 0; s < 40; s++) begin
      int len;
      bit l, e;
      len = $urandom_range(1, 40);
      l   = ($urandom_range(0, 9) != 0);
      e   = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < len; i++) step(l, e && ($urandom_range(0, 7) != 0));
    end
    repeat (5) step(1'b1, 1'b0);
    chk("pending_at_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
